bcd_dec_scan: RTL
=================

# bcd_dec_scan

Multi-digit, time-multiplexed BCD-to-decimal decoder. It is the parametrised successor to the single-digit 4-line-to-10-line decoder, and drives digit-strobed decimal indicator banks from a packed BCD word. A load handshake captures DIGITS packed BCD digits, and a pending buffer allows a new word to queue while a frame is scanning. The block then steps through the digits one at a time, each for SCAN_DIV cycles, and presents a registered active-low one-of-ten code with a one-hot digit strobe. Invalid codes (10–15) blank the outputs and are flagged.

## Interface
- DIGITS, 4: number of BCD digits, 1..16.
- SCAN_DIV, 4: clock cycles each digit is held, ≥1.
- CONTINUOUS, 1: 1 = repeat frames indefinitely; 0 = single-shot, return to IDLE after the frame.

- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- LOAD_VALID  in  1  BCD_IN valid.
- LOAD_READY  out  1  block can accept a word.
- BCD_IN  in  4*DIGITS  packed BCD; digit 0 = BCD_IN[3:0] (least significant).
- Y_N  out  10  active-low decimal output for the current digit; bit n low means digit value n.
- DIG_SEL  out  DIGITS  one-hot active-high strobe for the current digit.
- DIG_IDX  out  max(1,$clog2(DIGITS))  index of the current digit.
- FRAME_DONE  out  1  one-cycle pulse on the last cycle of the last digit.
- BCD_ERR  out  1  the active word contains at least one code above 9.

## Operation
- Registers:
  - active word;
  - pending word plus pend_full flag;
  - digit index;
  - divider count, 0..SCAN_DIV-1.
- States:
  - IDLE → SCAN: on an accepted load.
  - SCAN → SCAN: at frame end, when CONTINUOUS=1 or a word is pending or a load is accepted that cycle.
  - SCAN → IDLE: at frame end otherwise.
- LOAD_READY = !pend_full. A load is accepted when LOAD_VALID && LOAD_READY at a rising edge.
- Load acceptance by state:
  - In IDLE: the word goes directly to active, and scanning starts at digit 0.
  - In SCAN, not a frame-end cycle: the word goes to pending and pend_full is set.
  - In SCAN, frame-end cycle with pend_full=0: the word bypasses pending and becomes active for the next frame.
- Frame end with pend_full=1: pending moves to active and pend_full clears. LOAD_READY is high again in the following cycle.
- A frame with no new word (CONTINUOUS=1) rescans the same active word.
- Digit decode:
  - Value v ≤ 9: Y_N = ~(10'b1 << v).
  - Value v ≥ 10: Y_N = 10'h3FF (all high, the classic decoder behaviour). DIG_SEL still asserts.
- BCD_ERR is recomputed every time active is written:
  - set if any digit of the new active word is above 9;
  - cleared if all digits are valid.
- In IDLE: Y_N = 10'h3FF, DIG_SEL = 0, DIG_IDX holds 0.

## Timing
- Reset values (asynchronous, applied immediately, including mid-frame):
  - LOAD_READY = 1;
  - Y_N = 10'h3FF;
  - DIG_SEL = 0;
  - DIG_IDX = 0;
  - FRAME_DONE = 0;
  - BCD_ERR = 0.
- Reset discards both the pending and active words.
- All outputs are registered, and LOAD_READY is driven from flops.
- Load latency: load accepted at edge k in IDLE → at edge k+1, DIG_SEL[0]=1 and Y_N shows digit 0.
- Each digit is displayed for exactly SCAN_DIV cycles. A frame is DIGITS×SCAN_DIV cycles, with no gap between consecutive frames.
- FRAME_DONE is high for the cycle in which DIG_IDX = DIGITS-1 and the divider count is SCAN_DIV-1.
- Frame end in single-shot mode with nothing pending: IDLE outputs appear at the next edge.
- SCAN_DIV=1 and DIGITS=1 are legal. With both equal to 1, every SCAN cycle is a frame end.

## Configuration
- BCD_DEC_SCAN_LZB_EN (leading-zero blanking):
  - When defined, zero digits above the most significant non-zero digit drive Y_N = 10'h3FF while DIG_SEL still strobes. Digit 0 is never blanked.
  - An all-zero word therefore shows only digit 0 as "0".
  - When undefined, every zero digit drives Y_N = 10'h3FE.

## Structure
- Package bcd_dec_pkg holds:
  - the state enum {IDLE, SCAN};
  - localparam BCD_MAX = 9;
  - the all-off constant Y_OFF = 10'h3FF.
- Sub-module bcd_dec_1of10: combinational 4→10 active-low decoder with invalid-code blanking, instantiated once on the selected digit.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=2.
- Reset: RST_N low mid-frame → all outputs at their reset values that cycle; after release, LOAD_READY=1 and IDLE.
- Single-shot load (CONTINUOUS=0), BCD_IN=16'h5901:
  - Y_N = 3FD, 3FE, 1FF, 3DF, each for 2 cycles, with DIG_SEL = 1, 2, 4, 8;
  - FRAME_DONE on cycle 8, then IDLE.
- Invalid digit: load 16'h0C30 → digit 2 gives Y_N=3FF with DIG_SEL=4, and BCD_ERR=1; a following load of 16'h1234 → BCD_ERR=0 at its transfer.
- Continuous mode with pending word:
  - load 16'h1111, then 16'h2222 mid-frame → LOAD_READY=0 until frame end;
  - next frame shows 2222.
- Frame-end bypass: load presented on the FRAME_DONE cycle with nothing pending → next frame starts with the new word, with no gap.
- Blanking, with and without the macro, load 16'h0007:
  - with BCD_DEC_SCAN_LZB_EN: digits 1–3 give Y_N=3FF;
  - without the macro: digits 1–3 give Y_N=3FE.

Source files
------------

// File: rtl/bcd_dec_pkg.sv
// bcd_dec_pkg: shared state encoding and decode constants for bcd_dec_scan
package bcd_dec_pkg;
  typedef enum logic {IDLE, SCAN} state_e;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [9:0] Y_OFF = 10'h3FF;
endpackage

// File: rtl/bcd_dec_1of10.sv
// bcd_dec_1of10: combinational BCD to active-low one-of-ten decoder
//   bcd : 4-bit digit code
//   y_n : bit n low for value n; codes above 9 drive all outputs high
module bcd_dec_1of10 import bcd_dec_pkg::*; (
  input  logic [3:0] bcd,
  output logic [9:0] y_n
);
  always_comb y_n = (bcd <= BCD_MAX) ? ~(10'd1 << bcd) : Y_OFF;
endmodule

// File: rtl/bcd_dec_scan.sv
// bcd_dec_scan: time-multiplexed multi-digit BCD-to-decimal decoder
//   clk, rst_n               : clock, async active-low reset
//   load_valid/load_ready    : word handshake, bcd_in packed BCD (digit 0 in [3:0])
//   y_n, dig_sel, dig_idx    : registered active-low code, one-hot strobe, digit index
//   frame_done, bcd_err      : last-cycle-of-frame pulse, active word holds a code above 9
//   BCD_DEC_SCAN_LZB_EN      : define to blank leading zero digits (digit 0 never blanked)
module bcd_dec_scan import bcd_dec_pkg::*; #(
  parameter int DIGITS = 4,
  parameter int SCAN_DIV = 4,
  parameter bit CONTINUOUS = 1'b1,
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1,
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [9:0]            y_n,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [IW-1:0]         dig_idx,
  output logic                  frame_done,
  output logic                  bcd_err
);
  state_e state_q, state_d;
  logic [4*DIGITS-1:0] active_q, active_d, pend_q, pend_d;
  logic pend_full_q, pend_full_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0] y_n_q, y_n_d, dec_y_n;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic frame_done_q, frame_done_d, bcd_err_q, bcd_err_d;
  logic scan, fend, wrap, acc, take_pend, take_in, blank;
  logic [3:0] digit;
  // frame_done_q is exactly the frame-end condition of the current cycle
  always_comb begin
    scan = state_q == SCAN;
    fend = frame_done_q;
    wrap = cnt_q == CW'(SCAN_DIV - 1);
    acc = load_valid && !pend_full_q;
    take_pend = fend && pend_full_q;
    take_in = acc && (!scan || fend);
    active_d = take_pend ? pend_q : take_in ? bcd_in : active_q;
    pend_d = (acc && scan && !fend) ? bcd_in : pend_q;
    pend_full_d = scan && !fend && (pend_full_q || acc);
    state_d = (take_pend || take_in || (scan && (!fend || CONTINUOUS))) ? SCAN : IDLE;
    cnt_d = (scan && !wrap) ? cnt_q + 1'b1 : '0;
    idx_d = (!scan || fend) ? '0 : idx_q + IW'(wrap);
    digit = active_d[4*idx_d +: 4];
  end
  bcd_dec_1of10 u_dec (.bcd(digit), .y_n(dec_y_n));
  // outputs are registered from next-state values so they align with idx_q/cnt_q
  always_comb begin
    bcd_err_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) bcd_err_d = bcd_err_d | (active_d[4*i +: 4] > BCD_MAX);
`ifdef BCD_DEC_SCAN_LZB_EN
    blank = digit == 4'd0 && idx_d != '0;
    for (int i = 0; i < DIGITS; i++) if (i > int'(idx_d) && active_d[4*i +: 4] != 4'd0) blank = 1'b0;
`else
    blank = 1'b0;
`endif
    y_n_d = (state_d == SCAN && !blank) ? dec_y_n : Y_OFF;
    dig_sel_d = (state_d == SCAN) ? DIGITS'(1) << idx_d : '0;
    frame_done_d = state_d == SCAN && idx_d == IW'(DIGITS - 1) && cnt_d == CW'(SCAN_DIV - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      active_q <= '0;
      pend_q <= '0;
      pend_full_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      y_n_q <= Y_OFF;
      dig_sel_q <= '0;
      frame_done_q <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      active_q <= active_d;
      pend_q <= pend_d;
      pend_full_q <= pend_full_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      y_n_q <= y_n_d;
      dig_sel_q <= dig_sel_d;
      frame_done_q <= frame_done_d;
      bcd_err_q <= bcd_err_d;
    end
  assign load_ready = !pend_full_q;
  assign y_n = y_n_q;
  assign dig_sel = dig_sel_q;
  assign dig_idx = idx_q;
  assign frame_done = frame_done_q;
  assign bcd_err = bcd_err_q;
endmodule
